// File: rtl/debug_scratch_pkg.sv
// Shared types and constants for the debug scratch-pad word master.
// Holds the FSM state enum, default geometry and address field layout helpers.
package debug_scratch_pkg;

    localparam int DEPTH_LOG_DEF  = 8;
    localparam int WIDTH_LOG_DEF  = 3;
    localparam int BYTES_PER_WORD = 1 << WIDTH_LOG_DEF;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_e;

    // Scratch address = {lane, index}: lane occupies the upper bits.
    function automatic int lane_lsb(input int depth_log);
        return depth_log;
    endfunction

    function automatic int lane_msb(input int depth_log, input int width_log);
        return depth_log + width_log - 1;
    endfunction

endpackage

// File: rtl/debug_scratch_lane_next.sv
// Lowest-set-lane finder: returns the first lane >= lo_i whose mask bit is set.
// Ports: mask_i lane mask, lo_i inclusive lower bound, lane_o result, found_o hit.
module debug_scratch_lane_next #(
    parameter int WIDTH_LOG = 3
) (
    input  logic [(1<<WIDTH_LOG)-1:0] mask_i,
    input  logic [WIDTH_LOG:0]        lo_i,
    output logic [WIDTH_LOG-1:0]      lane_o,
    output logic                      found_o
);

    localparam int LANES = 1 << WIDTH_LOG;

    // Scan downward so the lowest qualifying lane is the last one written.
    always_comb begin
        lane_o  = '0;
        found_o = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_i[i] && ((WIDTH_LOG+1)'(i) >= lo_i)) begin
                lane_o  = WIDTH_LOG'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_scratch_word_master.sv
// Debug scratch-pad word master: turns 64-bit word requests into byte-lane
// accesses, one lane per cycle, on the debug data RAM scratch port.
// Ports: req_* request handshake (valid/ready, write, index, wdata),
//        resp_* response handshake (valid/ready, rdata),
//        scratch* byte port (addr = {lane, index}, wrdata, wren, rddata).
// Optional: DEBUG_SCRATCH_BYTE_MASK_EN adds req_bmask_i; writes then visit
//        only the masked lanes, reads still visit every lane.
module debug_scratch_word_master
    import debug_scratch_pkg::*;
#(
    parameter int DEPTH_LOG = DEPTH_LOG_DEF,
    parameter int WIDTH_LOG = WIDTH_LOG_DEF,
    parameter int WIDTH     = 8 * BYTES_PER_WORD
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_write_i,
    input  logic [DEPTH_LOG-1:0]           req_index_i,
    input  logic [WIDTH-1:0]               req_wdata_i,
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
    input  logic [WIDTH/8-1:0]             req_bmask_i,
`endif
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [WIDTH-1:0]               resp_rdata_o,
    output logic [DEPTH_LOG+WIDTH_LOG-1:0] scratchAddr_o,
    output logic [7:0]                     scratchWrData_o,
    output logic                           scratchWrEn_o,
    input  logic [7:0]                     scratchRdData_i
);

    localparam int LANES = 1 << WIDTH_LOG;
    localparam int LLSB  = lane_lsb(DEPTH_LOG);
    localparam int LMSB  = lane_msb(DEPTH_LOG, WIDTH_LOG);
    localparam logic [WIDTH_LOG-1:0] LANE_MAX = WIDTH_LOG'(LANES - 1);

    state_e               state_q, state_d;
    logic [WIDTH_LOG-1:0] lane_q, lane_d;
    logic                 write_q, write_d;
    logic [DEPTH_LOG-1:0] index_q, index_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH-1:0]     rdata_q, rdata_d;

    logic [WIDTH_LOG-1:0] start_lane;
    logic [WIDTH_LOG-1:0] lane_adv;
    logic                 lane_last;
    logic                 lane_wr;

`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
    logic [LANES-1:0]     bmask_q, bmask_d;
    logic [LANES-1:0]     acc_mask;
    logic [WIDTH_LOG-1:0] first_lane, next_lane;
    logic                 first_found, next_found;

    // Reads behave as a full mask so the lane walk is shared.
    assign acc_mask = req_write_i ? req_bmask_i : '1;

    debug_scratch_lane_next #(.WIDTH_LOG(WIDTH_LOG)) u_first (
        .mask_i  (acc_mask),
        .lo_i    ('0),
        .lane_o  (first_lane),
        .found_o (first_found)
    );

    debug_scratch_lane_next #(.WIDTH_LOG(WIDTH_LOG)) u_next (
        .mask_i  (bmask_q),
        .lo_i    ({1'b0, lane_q} + (WIDTH_LOG+1)'(1)),
        .lane_o  (next_lane),
        .found_o (next_found)
    );

    // Empty mask parks on lane 0 with its mask bit clear: one idle XFER cycle.
    assign start_lane = first_found ? first_lane : '0;
    assign lane_adv   = next_lane;
    assign lane_last  = !next_found;
    assign lane_wr    = bmask_q[lane_q];
`else
    assign start_lane = '0;
    assign lane_adv   = lane_q + WIDTH_LOG'(1);
    assign lane_last  = (lane_q == LANE_MAX);
    assign lane_wr    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            write_q <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
            bmask_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            write_q <= write_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
            bmask_q <= bmask_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        write_d = write_q;
        index_d = index_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        bmask_d = bmask_q;
`endif
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        resp_rdata_o    = '0;
        scratchAddr_o   = '0;
        scratchWrData_o = '0;
        scratchWrEn_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    write_d = req_write_i;
                    index_d = req_index_i;
                    wdata_d = req_wdata_i;
                    rdata_d = '0;
                    lane_d  = start_lane;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
                    bmask_d = acc_mask;
`endif
                    state_d = XFER;
                end
            end
            XFER: begin
                scratchAddr_o[LMSB:LLSB]   = lane_q;
                scratchAddr_o[LLSB-1:0]    = index_q;
                if (write_q) begin
                    scratchWrEn_o = lane_wr;
                    if (lane_wr) begin
                        scratchWrData_o = wdata_q[8*lane_q +: 8];
                    end
                end else begin
                    rdata_d[8*lane_q +: 8] = scratchRdData_i;
                end
                if (lane_last) begin
                    lane_d  = '0;
                    state_d = RESP;
                end else begin
                    lane_d = lane_adv;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = write_q ? '0 : rdata_q;
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences the port in the same cycle, so an aborted write
        // cannot land its current lane.
        if (reset) begin
            req_ready_o     = 1'b0;
            resp_valid_o    = 1'b0;
            resp_rdata_o    = '0;
            scratchAddr_o   = '0;
            scratchWrData_o = '0;
            scratchWrEn_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_scratch_word_master.sv
// Directed bench for debug_scratch_word_master with a byte RAM model.
// Covers write/read sequencing, back-pressure, top index, reset abort, masks.
module tb_debug_scratch_word_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [7:0]  req_index_i;
    logic [63:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic [10:0] scratchAddr_o;
    logic [7:0]  scratchWrData_o;
    logic        scratchWrEn_o;
    logic [7:0]  scratchRdData_i;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
    logic [7:0]  req_bmask_i;
`endif

    logic [7:0] mem [0:2047];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debug_scratch_word_master dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_write_i     (req_write_i),
        .req_index_i     (req_index_i),
        .req_wdata_i     (req_wdata_i),
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        .req_bmask_i     (req_bmask_i),
`endif
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_rdata_o    (resp_rdata_o),
        .scratchAddr_o   (scratchAddr_o),
        .scratchWrData_o (scratchWrData_o),
        .scratchWrEn_o   (scratchWrEn_o),
        .scratchRdData_i (scratchRdData_i)
    );

    assign scratchRdData_i = mem[scratchAddr_o];

    always @(posedge clk) begin
        if (scratchWrEn_o) mem[scratchAddr_o] <= scratchWrData_o;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wr, input logic [7:0] idx,
                             input logic [63:0] d);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_index_i = idx;
        req_wdata_i = d;
        check("ready_idle", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic xfer_write(input logic [7:0] idx, input logic [63:0] d);
        logic [10:0] a;
        for (int l = 0; l < 8; l++) begin
            a = {3'(l), idx};
            check("wr_addr", scratchAddr_o, a);
            check("wr_en", scratchWrEn_o, 1);
            check("wr_data", scratchWrData_o, d[8*l +: 8]);
            check("wr_ready_low", req_ready_o, 0);
            tick();
        end
        check("wr_resp_valid", resp_valid_o, 1);
        check("wr_resp_rdata", resp_rdata_o, 0);
        tick();
        check("wr_back_idle", req_ready_o, 1);
        for (int l = 0; l < 8; l++) begin
            a = {3'(l), idx};
            check("wr_mem", mem[a], d[8*l +: 8]);
        end
    endtask

    task automatic do_read(input logic [7:0] idx, input logic [63:0] exp);
        logic [10:0] a;
        start_req(1'b0, idx, 64'hDEAD_BEEF_DEAD_BEEF);
        for (int l = 0; l < 8; l++) begin
            a = {3'(l), idx};
            check("rd_addr", scratchAddr_o, a);
            check("rd_no_wren", scratchWrEn_o, 0);
            tick();
        end
        check("rd_resp_valid", resp_valid_o, 1);
        check("rd_resp_rdata", resp_rdata_o, exp);
        tick();
        check("rd_back_idle", req_ready_o, 1);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid_i  = 1'b0;
        req_write_i  = 1'b0;
        req_index_i  = '0;
        req_wdata_i  = '0;
        resp_ready_i = 1'b1;
`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        req_bmask_i  = 8'hFF;
`endif
        tick();
        tick();
        check("rst_ready", req_ready_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_wren", scratchWrEn_o, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", req_ready_o, 1);
        check("post_rst_addr", scratchAddr_o, 0);

        // Basic write then read-back of the same word.
        start_req(1'b1, 8'h05, 64'h0123_4567_89AB_CDEF);
        xfer_write(8'h05, 64'h0123_4567_89AB_CDEF);
        do_read(8'h05, 64'h0123_4567_89AB_CDEF);

        // Top index, read under back-pressure with a pending request.
        start_req(1'b1, 8'hFF, 64'hFFEE_DDCC_BBAA_9988);
        xfer_write(8'hFF, 64'hFFEE_DDCC_BBAA_9988);
        start_req(1'b0, 8'hFF, 64'h0);
        for (int l = 0; l < 8; l++) begin
            if (l == 7) begin
                check("top_addr", scratchAddr_o, 11'h7FF);
            end
            if (l == 6) begin
                resp_ready_i = 1'b0;
                req_valid_i  = 1'b1;
                req_write_i  = 1'b1;
                req_index_i  = 8'h10;
                req_wdata_i  = 64'h0F1E_2D3C_4B5A_6978;
            end
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", resp_valid_o, 1);
            check("bp_rdata", resp_rdata_o, 64'hFFEE_DDCC_BBAA_9988);
            check("bp_ready_low", req_ready_o, 0);
            check("bp_no_wren", scratchWrEn_o, 0);
            tick();
        end
        resp_ready_i = 1'b1;
        check("bp_valid_last", resp_valid_o, 1);
        tick();
        check("bp_idle_ready", req_ready_o, 1);
        check("bp_idle_resp", resp_valid_o, 0);
        tick();
        req_valid_i = 1'b0;
        xfer_write(8'h10, 64'h0F1E_2D3C_4B5A_6978);
        do_read(8'h10, 64'h0F1E_2D3C_4B5A_6978);

        // Reset during lane 3 of a write.
        start_req(1'b1, 8'h05, 64'hFEDC_BA98_7654_3210);
        tick();
        tick();
        tick();
        check("abort_lane3_addr", scratchAddr_o, 11'h305);
        check("abort_lane3_wren", scratchWrEn_o, 1);
        reset = 1'b1;
        #1;
        check("abort_wren_gated", scratchWrEn_o, 0);
        tick();
        check("abort_wren_after", scratchWrEn_o, 0);
        check("abort_ready_rst", req_ready_o, 0);
        reset = 1'b0;
        #1;
        check("abort_ready", req_ready_o, 1);
        for (int c = 0; c < 10; c++) begin
            check("abort_no_resp", resp_valid_o, 0);
            check("abort_no_wren", scratchWrEn_o, 0);
            tick();
        end
        check("abort_mem_l2", mem[11'h205], 8'h54);
        check("abort_mem_l3", mem[11'h305], 8'h89);
        do_read(8'h05, 64'h0123_4567_8954_3210);

`ifdef DEBUG_SCRATCH_BYTE_MASK_EN
        req_bmask_i = 8'h81;
        start_req(1'b1, 8'h33, 64'h1122_3344_5566_7788);
        req_bmask_i = 8'hFF;
        check("m81_addr0", scratchAddr_o, 11'h033);
        check("m81_en0", scratchWrEn_o, 1);
        check("m81_data0", scratchWrData_o, 8'h88);
        tick();
        check("m81_addr7", scratchAddr_o, 11'h733);
        check("m81_en7", scratchWrEn_o, 1);
        check("m81_data7", scratchWrData_o, 8'h11);
        tick();
        check("m81_resp", resp_valid_o, 1);
        tick();
        req_bmask_i = 8'h00;
        start_req(1'b1, 8'h34, 64'h1122_3344_5566_7788);
        req_bmask_i = 8'hFF;
        check("m00_no_wren", scratchWrEn_o, 0);
        check("m00_no_resp", resp_valid_o, 0);
        tick();
        check("m00_resp", resp_valid_o, 1);
        tick();
        check("m00_idle", req_ready_o, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
